mem_port_arbiter: RTL and testbench

Arbiter and sequencer for the single shared instruction/data memory port. Two requesters contend: the fetch unit (port F) and the load/store/MMU unit (port L). The block serialises their accesses, drives the memory, and routes read data back. Port L has fixed priority, and the block raises `mem_stall` toward fetch and the pipeline while L owns or wants the port.

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/mem_port_arbiter_starve_guard.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory port arbiter: default widths, state
// encoding, owner codes and an arbitration-point helper.
package mem_port_arbiter_pkg;

   localparam int ARB_ADDR_WIDTH = 32;
   localparam int ARB_DATA_WIDTH = 32;

   localparam logic [1:0] ARB_IDLE  = 2'd0;
   localparam logic [1:0] ARB_ISSUE = 2'd1;
   localparam logic [1:0] ARB_WAIT  = 2'd2;
   localparam logic [1:0] ARB_RESP  = 2'd3;

   localparam logic OWN_F = 1'b0;
   localparam logic OWN_L = 1'b1;

   // IDLE and RESP both pick the next owner, so back-to-back accesses need no idle gap.
   function automatic logic is_arb_point(input logic [1:0] state);
      return (state == ARB_IDLE) || (state == ARB_RESP);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester (F, L) and memory-side signals around the arbiter.
// slave = arbiter side, master = requesters plus memory.
interface mem_port_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  f_req_valid;
   logic [ADDR_WIDTH-1:0] f_addr;
   logic                  f_grant;
   logic [DATA_WIDTH-1:0] f_rdata;
   logic                  f_data_valid;
   logic                  flush;
   logic                  l_req_valid;
   logic                  l_we;
   logic [ADDR_WIDTH-1:0] l_addr;
   logic [DATA_WIDTH-1:0] l_wdata;
   logic                  l_grant;
   logic [DATA_WIDTH-1:0] l_rdata;
   logic                  l_data_valid;
   logic                  mem_stall;
   logic                  mem_en;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_ack;

   // Handshake: a requester holds req_valid and its address stable until it sees
   // its grant for one cycle; dropping req_valid before that withdraws the request.
   modport slave (
      input  f_req_valid, f_addr, flush, l_req_valid, l_we, l_addr, l_wdata,
             mem_rdata, mem_ack,
      output f_grant, f_rdata, f_data_valid, l_grant, l_rdata, l_data_valid,
             mem_stall, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output f_req_valid, f_addr, flush, l_req_valid, l_we, l_addr, l_wdata,
             mem_rdata, mem_ack,
      input  f_grant, f_rdata, f_data_valid, l_grant, l_rdata, l_data_valid,
             mem_stall, mem_en, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/mem_port_arbiter_starve_guard.sv
// Winner select with L priority, except that F is forced in after
// STARVE_LIMIT consecutive L wins taken while F was waiting.
module arb_starve_guard
   import mem_port_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               i_arb,
   input  logic                               i_f_req,
   input  logic                               i_l_req,
   output logic                               o_win_any,
   output logic                               o_win_l,
   output logic [$clog2(STARVE_LIMIT+1)-1:0]  o_count
);
   localparam int CW = $clog2(STARVE_LIMIT + 1);

   logic [CW-1:0] r_count;
   logic          w_force_f;

   assign w_force_f = i_f_req && (r_count == CW'(STARVE_LIMIT));
   assign o_win_any = i_arb & (i_f_req | i_l_req);
   assign o_win_l   = i_l_req & ~w_force_f;
   assign o_count   = r_count;

   // Any F win, or an arbitration with F absent, ends the starvation run.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_arb) begin
         if (!i_f_req || !o_win_l) begin
            r_count <= '0;
         end else if (r_count != CW'(STARVE_LIMIT)) begin
            r_count <= r_count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the shared memory port: L has priority over fetch.
// Define ARB_STARVE_GUARD_EN to bound how long fetch can be starved.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH   = ARB_ADDR_WIDTH,
   parameter int DATA_WIDTH   = ARB_DATA_WIDTH,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   mem_port_arbiter_if.slave                 io_arb,
   output logic [1:0]                        o_dbg_state,
   output logic [$clog2(STARVE_LIMIT+1)-1:0] o_dbg_starve_cnt
);
   logic [1:0]            r_state;
   logic                  r_owner;
   logic                  r_killed;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_we;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_f_grant, r_l_grant, r_mem_en;
   logic                  r_f_data_valid, r_l_data_valid;
   logic [DATA_WIDTH-1:0] r_f_rdata, r_l_rdata;

   logic w_f_req, w_l_req, w_arb, w_win_any, w_win_l;

   assign w_f_req = io_arb.f_req_valid & ~io_arb.flush;
   assign w_l_req = io_arb.l_req_valid;
   assign w_arb   = is_arb_point(r_state);

`ifdef ARB_STARVE_GUARD_EN
   arb_starve_guard #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve_guard (
      .clk       (clk),
      .reset     (reset),
      .i_arb     (w_arb),
      .i_f_req   (w_f_req),
      .i_l_req   (w_l_req),
      .o_win_any (w_win_any),
      .o_win_l   (w_win_l),
      .o_count   (o_dbg_starve_cnt)
   );
`else
   assign w_win_any        = w_arb & (w_f_req | w_l_req);
   assign w_win_l          = w_l_req;
   assign o_dbg_starve_cnt = '0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= ARB_IDLE;
         r_owner        <= OWN_F;
         r_killed       <= 1'b0;
         r_addr         <= '0;
         r_we           <= 1'b0;
         r_wdata        <= '0;
         r_f_grant      <= 1'b0;
         r_l_grant      <= 1'b0;
         r_mem_en       <= 1'b0;
         r_f_data_valid <= 1'b0;
         r_l_data_valid <= 1'b0;
         r_f_rdata      <= '0;
         r_l_rdata      <= '0;
      end else begin
         r_f_grant      <= 1'b0;
         r_l_grant      <= 1'b0;
         r_mem_en       <= 1'b0;
         r_f_data_valid <= 1'b0;
         r_l_data_valid <= 1'b0;
         case (r_state)
            ARB_IDLE, ARB_RESP: begin
               if (w_win_any) begin
                  r_owner   <= w_win_l ? OWN_L : OWN_F;
                  r_addr    <= w_win_l ? io_arb.l_addr : io_arb.f_addr;
                  r_we      <= w_win_l & io_arb.l_we;
                  r_wdata   <= w_win_l ? io_arb.l_wdata : '0;
                  r_killed  <= 1'b0;
                  r_f_grant <= ~w_win_l;
                  r_l_grant <= w_win_l;
                  r_mem_en  <= 1'b1;
                  r_state   <= ARB_ISSUE;
               end else begin
                  r_state <= ARB_IDLE;
               end
            end
            ARB_ISSUE: begin
               if (r_owner == OWN_F && io_arb.flush) r_killed <= 1'b1;
               r_state <= ARB_WAIT;
            end
            ARB_WAIT: begin
               if (r_owner == OWN_F && io_arb.flush) r_killed <= 1'b1;
               // A flush in the ack cycle itself still kills the fetch.
               if (io_arb.mem_ack) begin
                  if (r_owner == OWN_L) begin
                     r_l_rdata      <= io_arb.mem_rdata;
                     r_l_data_valid <= 1'b1;
                  end else begin
                     r_f_rdata      <= io_arb.mem_rdata;
                     r_f_data_valid <= ~(r_killed | io_arb.flush);
                  end
                  r_state <= ARB_RESP;
               end
            end
            default: r_state <= ARB_IDLE;
         endcase
      end
   end

   assign io_arb.f_grant      = r_f_grant;
   assign io_arb.l_grant      = r_l_grant;
   assign io_arb.f_data_valid = r_f_data_valid;
   assign io_arb.l_data_valid = r_l_data_valid;
   assign io_arb.f_rdata      = r_f_rdata;
   assign io_arb.l_rdata      = r_l_rdata;
   assign io_arb.mem_en       = r_mem_en;
   assign io_arb.mem_we       = r_we;
   assign io_arb.mem_addr     = r_addr;
   assign io_arb.mem_wdata    = r_wdata;
   assign io_arb.mem_stall    = ~reset & (w_l_req | (r_owner == OWN_L && r_state != ARB_IDLE));
   assign o_dbg_state         = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized F/L traffic checked against an ordered transaction model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 4;
  localparam int EW = 66;  // {own_l, we, addr, wdata}

  logic clk = 1'b0;
  logic reset;
  logic [1:0] dbg_state;
  logic [$clog2(SL+1)-1:0] dbg_cnt;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
    .clk              (clk),
    .reset            (reset),
    .io_arb           (bus.slave),
    .o_dbg_state      (dbg_state),
    .o_dbg_starve_cnt (dbg_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];   // expected memory issues, in order
  logic [EW-1:0] done_q[$];  // expected completions, in order
  int n_done = 0;
  bit mon_en = 0;
  bit auto_mem = 0;
  int max_lat = 1;
  int mem_cnt = 0;
  logic [31:0] mem_raddr = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // memory contents as a fixed function of address
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // driver: advance one clock, then act as the memory when auto_mem is set
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_mem) begin
      bus.mem_ack = 1'b0;
      if (bus.mem_en) begin
        mem_cnt   = $urandom_range(1, max_lat);
        mem_raddr = bus.mem_addr;
      end else if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem_fn(mem_raddr);
        end
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_f_grant"},   bus.f_grant, 0);
    chk({tag, "_l_grant"},   bus.l_grant, 0);
    chk({tag, "_f_dv"},      bus.f_data_valid, 0);
    chk({tag, "_l_dv"},      bus.l_data_valid, 0);
    chk({tag, "_f_rdata"},   bus.f_rdata, 0);
    chk({tag, "_l_rdata"},   bus.l_rdata, 0);
    chk({tag, "_mem_en"},    bus.mem_en, 0);
    chk({tag, "_mem_we"},    bus.mem_we, 0);
    chk({tag, "_mem_addr"},  bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_mem_stall"}, bus.mem_stall, 0);
    chk({tag, "_state"},     dbg_state, ARB_IDLE);
  endtask

  // scoreboard: compare every issue and completion with the model queues
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!reset && mon_en) begin
      if (bus.mem_en) begin
        chk("issue_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("mem_addr", bus.mem_addr, e[63:32]);
          chk("mem_we", bus.mem_we, e[64]);
          if (e[64]) chk("mem_wdata", bus.mem_wdata, e[31:0]);
          chk("grant_owner", {bus.l_grant, bus.f_grant}, e[65] ? 2'b10 : 2'b01);
          done_q.push_back(e);
        end
      end
      if (bus.f_data_valid || bus.l_data_valid) begin
        chk("done_expected", done_q.size() > 0, 1);
        if (done_q.size() > 0) begin
          e = done_q.pop_front();
          chk("dv_owner", {bus.l_data_valid, bus.f_data_valid}, e[65] ? 2'b10 : 2'b01);
          if (!e[64]) chk("rdata", e[65] ? bus.l_rdata : bus.f_rdata, mem_fn(e[63:32]));
        end
        n_done++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int seq[6];
  int ng, mode, want, target, cyc;
  logic [31:0] fa, la, lwd;
  logic lwe;

  initial begin
    reset = 1'b1;
    bus.f_req_valid = 0; bus.f_addr = '0; bus.flush = 0;
    bus.l_req_valid = 1; bus.l_we = 0; bus.l_addr = '0; bus.l_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ack = 0;

    // reset: everything zero, mem_stall held low even with L requesting
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    chk("reset_starve_cnt", dbg_cnt, 0);
    bus.l_req_valid = 0;
    reset = 1'b0;
    tick();

    // single fetch read, ack one cycle after ISSUE
    bus.f_req_valid = 1; bus.f_addr = 32'h10;
    tick();
    chk("sf_f_grant", bus.f_grant, 1);
    chk("sf_mem_en", bus.mem_en, 1);
    chk("sf_mem_addr", bus.mem_addr, 32'h10);
    chk("sf_mem_we", bus.mem_we, 0);
    chk("sf_stall_issue", bus.mem_stall, 0);
    bus.f_req_valid = 0;
    tick();
    chk("sf_grant_pulse", bus.f_grant, 0);
    chk("sf_mem_en_pulse", bus.mem_en, 0);
    chk("sf_addr_hold", bus.mem_addr, 32'h10);
    bus.mem_ack = 1; bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.mem_ack = 0;
    chk("sf_f_dv", bus.f_data_valid, 1);
    chk("sf_f_rdata", bus.f_rdata, 32'hDEAD_BEEF);
    chk("sf_l_dv", bus.l_data_valid, 0);
    chk("sf_stall_resp", bus.mem_stall, 0);
    tick();
    chk("sf_dv_pulse", bus.f_data_valid, 0);
    chk("sf_idle", dbg_state, ARB_IDLE);

    // simultaneous: L write wins, F follows from L's RESP
    bus.f_req_valid = 1; bus.f_addr = 32'h20;
    bus.l_req_valid = 1; bus.l_we = 1; bus.l_addr = 32'h40; bus.l_wdata = 32'h55;
    #1;
    chk("sim_stall_req", bus.mem_stall, 1);
    tick();
    chk("sim_l_grant", bus.l_grant, 1);
    chk("sim_f_grant0", bus.f_grant, 0);
    chk("sim_mem_we", bus.mem_we, 1);
    chk("sim_mem_addr", bus.mem_addr, 32'h40);
    chk("sim_mem_wdata", bus.mem_wdata, 32'h55);
    chk("sim_stall_issue", bus.mem_stall, 1);
    bus.l_req_valid = 0; bus.l_we = 0;
    tick();
    chk("sim_stall_wait", bus.mem_stall, 1);
    bus.mem_ack = 1; bus.mem_rdata = '0;
    tick();
    bus.mem_ack = 0;
    chk("sim_l_dv", bus.l_data_valid, 1);
    chk("sim_f_dv0", bus.f_data_valid, 0);
    chk("sim_stall_resp", bus.mem_stall, 1);
    tick();
    chk("sim_f_grant", bus.f_grant, 1);
    chk("sim_f_addr", bus.mem_addr, 32'h20);
    chk("sim_f_we", bus.mem_we, 0);
    chk("sim_stall_f", bus.mem_stall, 0);
    bus.f_req_valid = 0;
    tick();
    bus.mem_ack = 1; bus.mem_rdata = 32'h1234_5678;
    tick();
    bus.mem_ack = 0;
    chk("sim_f_dv", bus.f_data_valid, 1);
    chk("sim_f_rdata", bus.f_rdata, 32'h1234_5678);
    chk("sim_l_dv0", bus.l_data_valid, 0);
    tick();

    // flush mid-fetch; an ack during ISSUE must be ignored
    bus.f_req_valid = 1; bus.f_addr = 32'h30;
    tick();
    chk("fl_f_grant", bus.f_grant, 1);
    bus.f_req_valid = 0;
    bus.mem_ack = 1; bus.mem_rdata = 32'h0000_0BAD;
    tick();
    bus.mem_ack = 0; bus.flush = 1;
    chk("fl_wait", dbg_state, ARB_WAIT);
    tick();
    bus.flush = 0;
    chk("fl_stale_ack_ignored", dbg_state, ARB_WAIT);
    bus.mem_ack = 1; bus.mem_rdata = 32'h0BAD_F00D;
    tick();
    bus.mem_ack = 0;
    chk("fl_dv_killed", bus.f_data_valid, 0);
    chk("fl_resp", dbg_state, ARB_RESP);
    bus.f_req_valid = 1; bus.f_addr = 32'h34;
    tick();
    chk("fl_next_grant", bus.f_grant, 1);
    chk("fl_next_addr", bus.mem_addr, 32'h34);
    bus.f_req_valid = 0;
    tick();
    bus.mem_ack = 1; bus.mem_rdata = 32'hCAFE_0001;
    tick();
    bus.mem_ack = 0;
    chk("fl_next_dv", bus.f_data_valid, 1);
    chk("fl_next_rdata", bus.f_rdata, 32'hCAFE_0001);
    tick();
    // a fetch request under flush is not arbitrated
    bus.f_req_valid = 1; bus.flush = 1;
    tick();
    chk("fl_req_blocked", bus.f_grant, 0);
    chk("fl_req_blocked_state", dbg_state, ARB_IDLE);
    bus.f_req_valid = 0; bus.flush = 0;
    tick();

    // reset during WAIT, then a stale ack
    bus.l_req_valid = 1; bus.l_we = 0; bus.l_addr = 32'h50;
    tick();
    chk("rw_l_grant", bus.l_grant, 1);
    bus.l_req_valid = 0;
    tick();
    chk("rw_stall_wait", bus.mem_stall, 1);
    reset = 1'b1;
    #1;
    chk_all_zero("rw_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.mem_ack = 1; bus.mem_rdata = 32'h77;
    tick();
    bus.mem_ack = 0;
    chk("rw_stale_l_dv", bus.l_data_valid, 0);
    chk("rw_stale_f_dv", bus.f_data_valid, 0);
    chk("rw_stale_l_rdata", bus.l_rdata, 0);
    chk("rw_stale_state", dbg_state, ARB_IDLE);
    tick();
    chk("rw_stale_l_dv2", bus.l_data_valid, 0);

    // starvation: L requests continuously while F waits
    auto_mem = 1; max_lat = 1; mem_cnt = 0;
    for (int i = 0; i < 6; i++) seq[i] = 2;
    ng = 0;
    bus.l_req_valid = 1; bus.l_we = 0; bus.l_addr = 32'h60;
    bus.f_req_valid = 1; bus.f_addr = 32'h70;
    for (int c = 0; c < 80 && ng < 6; c++) begin
      tick();
      if (bus.l_grant) begin seq[ng] = 1; ng++; end
      if (bus.f_grant && ng < 6) begin seq[ng] = 0; ng++; bus.f_req_valid = 0; end
      if (ng >= 6) begin bus.l_req_valid = 0; bus.f_req_valid = 0; end
    end
    bus.l_req_valid = 0; bus.f_req_valid = 0;
    for (int i = 0; i < 6; i++) begin
`ifdef ARB_STARVE_GUARD_EN
      chk($sformatf("starve_seq%0d", i), seq[i], (i == SL) ? 0 : 1);
`else
      chk($sformatf("starve_seq%0d", i), seq[i], 1);
`endif
    end
    for (int c = 0; c < 20 && dbg_state != ARB_IDLE; c++) tick();
    tick();

    // randomized traffic against the ordered model
    max_lat = 3; mon_en = 1;
    for (int it = 0; it < 40; it++) begin
      mode = $urandom_range(0, 2);  // 0: F only, 1: L only, 2: both
      fa  = $urandom & 32'h0000_FFFC;
      la  = $urandom & 32'h0000_FFFC;
      lwe = 1'($urandom_range(0, 1));
      lwd = $urandom;
      want = 0;
      if (mode != 0) begin exp_q.push_back({1'b1, lwe, la, lwe ? lwd : 32'h0}); want++; end
      if (mode != 1) begin exp_q.push_back({1'b0, 1'b0, fa, 32'h0}); want++; end
      bus.f_req_valid = (mode != 1); bus.f_addr = fa;
      bus.l_req_valid = (mode != 0); bus.l_addr = la; bus.l_we = lwe; bus.l_wdata = lwd;
      target = n_done + want;
      cyc = 0;
      while (n_done < target && cyc < 40) begin
        tick();
        cyc++;
        if (bus.f_grant) bus.f_req_valid = 0;
        if (bus.l_grant) bus.l_req_valid = 0;
      end
      chk("rand_txn_complete", n_done, target);
      bus.f_req_valid = 0; bus.l_req_valid = 0;
      repeat ($urandom_range(0, 2)) tick();
    end
    for (int c = 0; c < 20 && dbg_state != ARB_IDLE; c++) tick();
    mon_en = 0;
    chk("rand_issue_q_empty", exp_q.size(), 0);
    chk("rand_done_q_empty", done_q.size(), 0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
